// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes. Each
// iteration retires BITS_PER_CYCLE bits. Sign correction and result
// selection happen in a final FINISH cycle. Divide-by-zero and signed
// overflow skip the iteration phase.
module muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;        // mul: unused in ITER; div: dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   r_b;        // mul: multiplier shifting right; div: divisor
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_rem;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_a, r_neg_b, r_dz, r_ovf;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic              w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [2*XLEN-1:0] w_prod_it, w_mcand_it, w_prod_fix;
  logic [XLEN-1:0]   w_mplr_it, w_quo_it, w_rem_it, w_sel;
  logic [XLEN:0]     w_sh;

  // Operand decode: signedness, magnitudes and fast-path detection.
  always_comb begin
    w_accept   = (r_state == S_IDLE) && start && !flush;
    w_sgn_a    = !((funct3 == F_MULHU) || (funct3 == F_DIVU) || (funct3 == F_REMU));
    w_sgn_b    = w_sgn_a && (funct3 != F_MULHSU);
    w_neg_a    = w_sgn_a && operandA[XLEN-1];
    w_neg_b    = w_sgn_b && operandB[XLEN-1];
    w_mag_a    = w_neg_a ? -operandA : operandA;
    w_mag_b    = w_neg_b ? -operandB : operandB;
    w_div_zero = (operandB == '0);
    w_ovf      = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
    w_fast     = funct3[2] && (w_div_zero || w_ovf);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_fast ? S_FINISH : S_ITER;
      S_ITER:   if (r_cnt == CW'(1)) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // One iteration step: both multiply and divide paths computed, op selects.
  always_comb begin
    w_prod_it = r_prod;
    w_quo_it  = r_a;
    w_rem_it  = r_rem;
    w_sh      = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_b[i]) w_prod_it = w_prod_it + (r_mcand << i);
      w_sh     = {w_rem_it, w_quo_it[XLEN-1]};
      w_quo_it = {w_quo_it[XLEN-2:0], 1'b0};
      if (w_sh >= {1'b0, r_b}) begin
        w_sh        = w_sh - {1'b0, r_b};
        w_quo_it[0] = 1'b1;
      end
      w_rem_it = w_sh[XLEN-1:0];
    end
    w_mcand_it = r_mcand << BITS_PER_CYCLE;
    w_mplr_it  = r_b >> BITS_PER_CYCLE;
  end

  // Operand latch on accept, then iterate while in ITER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= funct3;
      // fast path keeps the raw dividend: it is the DIV overflow quotient and the div-by-zero remainder
      r_a     <= w_fast ? operandA : w_mag_a;
      r_b     <= w_mag_b;
      r_mcand <= {{XLEN{1'b0}}, w_mag_a};
      r_prod  <= '0;
      r_rem   <= '0;
      r_cnt   <= CW'(N);
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_dz    <= w_div_zero;
      r_ovf   <= w_ovf;
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op[2]) begin
        r_a   <= w_quo_it;
        r_rem <= w_rem_it;
      end else begin
        r_prod  <= w_prod_it;
        r_mcand <= w_mcand_it;
        r_b     <= w_mplr_it;
      end
    end
  end

  // Sign correction and result select.
  always_comb begin
    w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;
    case (r_op)
      F_MUL:         w_sel = w_prod_fix[XLEN-1:0];
      F_DIV, F_DIVU: w_sel = r_dz ? '1 : r_ovf ? r_a : ((r_neg_a ^ r_neg_b) ? -r_a : r_a);
      F_REM, F_REMU: w_sel = r_dz ? r_a : r_ovf ? '0 : (r_neg_a ? -r_rem : r_rem);
      default:       w_sel = w_prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Result register and done pulse; a flush in FINISH suppresses both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else if ((r_state == S_FINISH) && !flush) begin
      r_done   <= 1'b1;
      r_result <= w_sel;
    end else begin
      r_done   <= 1'b0;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: three instances (1, 2 and 4 bits per
// cycle) share stimulus; expected results come from a plain-arithmetic model.
module tb_muldiv_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [2:0]  busy_w, done_w;
  logic [31:0] res_w [3];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst_n), .start(start), .funct3(funct3), .operandA(opa),
    .operandB(opb), .flush(flush), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .rst(rst_n), .start(start), .funct3(funct3), .operandA(opa),
    .operandB(opb), .flush(flush), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst_n), .start(start), .funct3(funct3), .operandA(opa),
    .operandB(opb), .flush(flush), .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]));

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    bit          fast;
  } exp_t;

  exp_t        exp_q[$];
  int          rd[3] = '{0, 0, 0};
  logic [31:0] last[3] = '{32'h0, 32'h0, 32'h0};
  int unsigned cyc = 0;
  int          npass = 0;
  int          nchk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] pa, pb, p;
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    pa = (f == 3'b011) ? {34'b0, a} : {{34{a[31]}}, a};
    pb = (f == 3'b000 || f == 3'b001) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = pa * pb;
    case (f)
      3'b000: r = p[31:0];
      3'b001, 3'b010, 3'b011: r = p[63:32];
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? MIN : 32'(sa / sb);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF));
  endfunction

  function automatic int unsigned lat(input int k, input bit fast);
    if (fast) return 2;
    return (k == 0) ? 34 : (k == 1) ? 18 : 10;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < 3; k++) if (rd[k] < exp_q.size()) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every done is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        rd[k]   = exp_q.size();
        last[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          if (rd[k] >= exp_q.size()) begin
            nchk++;
            $display("FAIL unexpected_done dut%0d: got done=1 result %h required no done", k, res_w[k]);
          end else begin
            exp_t e;
            e = exp_q[rd[k]];
            check($sformatf("result dut%0d op#%0d", k, rd[k]), res_w[k], e.res);
            check($sformatf("done_cycle dut%0d", k), 32'(cyc), 32'(e.cyc + lat(k, e.fast)));
            check($sformatf("busy_at_done dut%0d", k), {31'b0, busy_w[k]}, 32'h0);
            last[k] = e.res;
            rd[k]++;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    funct3 = f;
    opa    = a;
    opb    = b;
    start  = 1'b1;
    if (push) begin
      e.res  = model(f, a, b);
      e.cyc  = cyc;
      e.fast = is_fast(f, a, b);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("busy_cycle1 dut%0d", k), {31'b0, busy_w[k]}, 32'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_w != 3'b000 || pending()) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      nchk++;
      $display("FAIL wait_idle: got busy=%b after 300 cycles required idle", busy_w);
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b, 1'b1);
    wait_idle();
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", {31'b0, busy_w[k]}, 32'h0);
      check("reset_done", {31'b0, done_w[k]}, 32'h0);
      check("reset_result", res_w[k], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MUL then MULH, second start in the BPC=1 done cycle
    issue(3'b000, 32'hFFFF_FFF9, 32'd3, 1'b1);
    repeat (33) @(posedge clk);
    #1;
    issue(3'b001, 32'hFFFF_FFF9, 32'd3, 1'b1);
    wait_idle();

    run(3'b100, 32'hFFFF_FFF9, 32'd2);
    run(3'b110, 32'hFFFF_FFF9, 32'd2);
    run(3'b101, 32'd100, 32'd7);
    run(3'b111, 32'd100, 32'd7);
    run(3'b101, 32'h1234_5678, 32'h0);
    run(3'b110, 32'h1234_5678, 32'h0);
    run(3'b100, MIN, 32'hFFFF_FFFF);
    run(3'b110, MIN, 32'hFFFF_FFFF);
    run(3'b101, MIN, 32'hFFFF_FFFF);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'b010, MIN, 32'hFFFF_FFFF);

    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = MIN; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run(rf, ra, rb);
    end

    // flush mid-operation: no done, result unchanged
    issue(3'b101, 32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < 3; k++) check("busy_after_flush", {31'b0, busy_w[k]}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("result_kept_flush", res_w[k], last[k]);

    // flush together with start in IDLE: nothing accepted
    funct3 = 3'b000; opa = 32'd5; opb = 32'd9;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) check("busy_flush_start", {31'b0, busy_w[k]}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("result_kept_flush_start", res_w[k], last[k]);

    // reset dropped in cycle 10 of a MUL
    issue(3'b000, 32'h0001_2345, 32'h0000_0777, 1'b1);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("midreset_busy", {31'b0, busy_w[k]}, 32'h0);
      check("midreset_done", {31'b0, done_w[k]}, 32'h0);
      check("midreset_result", res_w[k], 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b000, 32'd6, 32'd7, 1'b1);
    repeat (33) @(posedge clk);
    #1;
    issue(3'b000, 32'hFFFF_FFF0, 32'd12, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage, parametrised in operand width and bits retired per cycle. It accepts one operation on a start pulse, raises busy so the freeze logic can hold the pipeline barriers, and returns a registered result with a one-cycle done pulse. Divide-by-zero and signed overflow complete on a fast path without iterating. Flush from a taken branch aborts the operation in flight.

## Interface
- XLEN, 32: operand and result width. Must be even.
- BITS_PER_CYCLE, 1: bits retired per iteration. Allowed values are 1, 2 and 4, and the value must divide XLEN. N = XLEN/BITS_PER_CYCLE.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  in  XLEN  rs1 value (multiplicand / dividend).
- operandB  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  abort; dominates start.
- busy  out  1  high while an operation is in flight; feeds the freeze unit.
- done  out  1  single-cycle pulse; result is valid in that cycle.
- result  out  XLEN  registered; holds its value until the next done.

## Operation
- States:
  - IDLE: waits for start.
  - ITER: N cycles, one iteration per cycle.
  - FINISH: one cycle of sign correction and result select.
- IDLE -> ITER: start=1 and flush=0. On this edge the unit latches funct3, the operand magnitudes, the sign flags and iteration counter = N.
- IDLE -> FINISH (fast path), divide ops only:
  - operandB = 0.
  - DIV/REM with operandA = 1 followed by XLEN-1 zeros and operandB all ones.
- ITER: decrements the counter each cycle. When counter reaches 1, next state is FINISH.
- FINISH -> IDLE: registers result and sets done=1 for the following cycle.
- Multiply: shift-add of unsigned magnitudes into a 2*XLEN product, BITS_PER_CYCLE multiplier bits per cycle.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - The product is negated when exactly one counted operand is negative. MULH treats both operands as signed, MULHSU only A, MULHU neither.
- Divide: restoring division of magnitudes, BITS_PER_CYCLE quotient bits per cycle.
  - Signed DIV: quotient sign = signA XOR signB.
  - Signed REM: remainder sign = signA.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = original operandA.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0.
- start while busy=1 is ignored; the caller re-presents it after done.
- flush=1 in any state forces IDLE on the next edge. No done is issued and result keeps its previous value.
- flush and start together in IDLE: flush wins and nothing is accepted.
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Normal path:
  - busy=1 in cycles 1..N+1.
  - done=1 and result valid in cycle N+2; busy=0 in that cycle.
  - XLEN=32, BPC=1: done in cycle 34.
  - XLEN=32, BPC=4: done in cycle 10.
- Fast path: busy=1 in cycle 1; done=1 in cycle 2.
- Back-to-back: a new start may be sampled in the done cycle (N+2). Its done follows N+2 cycles later, with no dead cycle.
- busy is registered and asserts no earlier than cycle 1. The stall unit must block the instruction behind a M-op in cycle 0 combinationally from start.
- Outputs depend only on registers; there are no combinational input-to-output paths.
- Reset mid-operation: all outputs are at reset values from the assertion instant. After deassertion the first start behaves like cycle 0.

## Test plan
- MUL then MULH, operandA=0xFFFFFFF9 (-7), operandB=3 -> result 0xFFFFFFEB in cycle 34, then 0xFFFFFFFF; done high exactly one cycle each.
- DIV then REM, -7 and 2 -> 0xFFFFFFFD (-3), then 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x12345678/0 -> 0xFFFFFFFF in cycle 2; REM 0x12345678/0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both done in cycle 2.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, repeated with BITS_PER_CYCLE=2 and 4; done in cycles 18 and 10 respectively.
- Start DIVU, pulse flush in cycle 5 -> busy=0 in cycle 6, no done, result unchanged. Then flush+start together in IDLE -> nothing accepted.
- Drop rst in cycle 10 of a MUL -> busy, done and result read 0 immediately. Release, start MUL 6*7 -> 42 in cycle 34. A second start in the done cycle is accepted back-to-back.
